adc_scan_averager: RTL

- Parametrised scan sequencer that drives the modular ADC control core's command/response streams.
- Walks a runtime channel mask, issues 2^AVG_LOG2 back-to-back conversions per enabled channel and averages them.
- Presents one averaged sample per channel on a valid/ready output stream.
- Sits between the ADC core and the sample consumers (audio/control logic), replacing single-shot command generation.

---
 rtl/adc_scan_averager.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_averager.sv
// Scan sequencer for the modular ADC core: walks a channel mask and averages 2^AVG_LOG2 conversions per channel.
// Optional macro ADC_SCAN_CHANNEL_CHECK_EN: discard responses from the wrong channel and flag chan_error.
module adc_scan_averager #(
   parameter int NUM_CH   = 9,
   parameter int CH_W     = 5,
   parameter int DATA_W   = 12,
   parameter int AVG_LOG2 = 2
) (
   input  logic              clock_clk,
   input  logic              reset_sink_reset_n,
   input  logic              enable,
   input  logic [NUM_CH-1:0] channel_mask,
   output logic              command_valid,
   output logic [CH_W-1:0]   command_channel,
   output logic              command_startofpacket,
   output logic              command_endofpacket,
   input  logic              command_ready,
   input  logic              response_valid,
   input  logic [CH_W-1:0]   response_channel,
   input  logic [DATA_W-1:0] response_data,
   input  logic              response_startofpacket,
   input  logic              response_endofpacket,
   output logic              sample_valid,
   output logic [CH_W-1:0]   sample_channel,
   output logic [DATA_W-1:0] sample_data,
   input  logic              sample_ready,
   output logic              overrun,
   input  logic              clear_overrun,
   output logic              busy
`ifdef ADC_SCAN_CHANNEL_CHECK_EN
   ,
   output logic              chan_error
`endif
);

   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int NCONV = 1 << AVG_LOG2;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, EMIT} state_t;

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   scan_mask_q, scan_mask_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                smp_vld_q, smp_vld_d;
   logic [CH_W-1:0]     smp_ch_q, smp_ch_d;
   logic [DATA_W-1:0]   smp_data_q, smp_data_d;
   logic                overrun_q, overrun_d;
   logic                resp_ok;
   logic                unused_resp_framing;

   assign unused_resp_framing = response_startofpacket ^ response_endofpacket;

   function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
      lowest_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) lowest_ch = CH_W'(i);
   endfunction

   function automatic logic [CH_W-1:0] highest_ch(input logic [NUM_CH-1:0] m);
      highest_ch = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (m[i]) highest_ch = CH_W'(i);
   endfunction

   function automatic logic has_next(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] c);
      has_next = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
         if (m[i] && (i > int'(c))) has_next = 1'b1;
   endfunction

   function automatic logic [CH_W-1:0] next_ch(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] c);
      next_ch = c;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i] && (i > int'(c))) next_ch = CH_W'(i);
   endfunction

   // Truncating average: drop the AVG_LOG2 fractional bits of the sum.
   function automatic logic [DATA_W-1:0] avg_of(input logic [ACC_W-1:0] a);
      avg_of = DATA_W'(a >> AVG_LOG2);
   endfunction

`ifdef ADC_SCAN_CHANNEL_CHECK_EN
   logic chan_err_q, chan_err_d;
   assign resp_ok    = response_valid && (response_channel == ch_q);
   assign chan_error = chan_err_q;
`else
   logic unused_resp_channel;
   assign resp_ok             = response_valid;
   assign unused_resp_channel = ^response_channel;
`endif

   always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
      if (!reset_sink_reset_n) begin
         state_q     <= IDLE;
         scan_mask_q <= '0;
         ch_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         smp_vld_q   <= 1'b0;
         smp_ch_q    <= '0;
         smp_data_q  <= '0;
         overrun_q   <= 1'b0;
`ifdef ADC_SCAN_CHANNEL_CHECK_EN
         chan_err_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         scan_mask_q <= scan_mask_d;
         ch_q        <= ch_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         smp_vld_q   <= smp_vld_d;
         smp_ch_q    <= smp_ch_d;
         smp_data_q  <= smp_data_d;
         overrun_q   <= overrun_d;
`ifdef ADC_SCAN_CHANNEL_CHECK_EN
         chan_err_q  <= chan_err_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      scan_mask_d = scan_mask_q;
      ch_d        = ch_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      smp_vld_d   = smp_vld_q && !sample_ready;
      smp_ch_d    = smp_ch_q;
      smp_data_d  = smp_data_q;
      overrun_d   = clear_overrun ? 1'b0 : overrun_q;
`ifdef ADC_SCAN_CHANNEL_CHECK_EN
      chan_err_d  = clear_overrun ? 1'b0 : chan_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (enable && (|channel_mask)) begin
               scan_mask_d = channel_mask;
               ch_d        = lowest_ch(channel_mask);
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (command_ready) state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
`ifdef ADC_SCAN_CHANNEL_CHECK_EN
            if (response_valid && !resp_ok) chan_err_d = 1'b1;
`endif
            if (resp_ok) begin
               acc_d   = acc_q + ACC_W'(response_data);
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = (cnt_d == CNT_W'(NCONV)) ? EMIT : ISSUE;
            end
         end
         EMIT: begin
            // A held sample that is not being taken this cycle wins; the new one is lost.
            if (!smp_vld_q || sample_ready) begin
               smp_vld_d  = 1'b1;
               smp_ch_d   = ch_q;
               smp_data_d = avg_of(acc_q);
            end else begin
               overrun_d = 1'b1;
            end
            acc_d = '0;
            cnt_d = '0;
            if (!enable) begin
               state_d = IDLE;
            end else if (has_next(scan_mask_q, ch_q)) begin
               ch_d    = next_ch(scan_mask_q, ch_q);
               state_d = ISSUE;
            end else if (|channel_mask) begin
               scan_mask_d = channel_mask;
               ch_d        = lowest_ch(channel_mask);
               state_d     = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      command_valid         = 1'b0;
      command_channel       = '0;
      command_startofpacket = 1'b0;
      command_endofpacket   = 1'b0;
      if (state_q == ISSUE) begin
         command_valid         = 1'b1;
         command_channel       = ch_q;
         command_startofpacket = (cnt_q == '0) && (ch_q == lowest_ch(scan_mask_q));
         command_endofpacket   = (cnt_q == CNT_W'(NCONV - 1)) && (ch_q == highest_ch(scan_mask_q));
      end
   end

   assign busy           = (state_q != IDLE);
   assign sample_valid   = smp_vld_q;
   assign sample_channel = smp_ch_q;
   assign sample_data    = smp_data_q;
   assign overrun        = overrun_q;

endmodule
